// File: rtl/axi4_mem_if.sv
// axi4_mem_if: AXI4 AW/W/B/AR/R channel bundle; master drives requests, slave drives responses
interface axi4_mem_if #(
  parameter int ID_W = 6,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic aw_valid, aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [ID_W-1:0] aw_id;
  logic [7:0] aw_len;
  logic [2:0] aw_size;
  logic [1:0] aw_burst;
  logic w_valid, w_ready, w_last;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic b_valid, b_ready;
  logic [ID_W-1:0] b_id;
  logic [1:0] b_resp;
  logic ar_valid, ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0] ar_id;
  logic [7:0] ar_len;
  logic [2:0] ar_size;
  logic [1:0] ar_burst;
  logic r_valid, r_ready, r_last;
  logic [DATA_W-1:0] r_data;
  logic [ID_W-1:0] r_id;
  logic [1:0] r_resp;
  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, w_valid, w_data, w_strb, w_last,
           b_ready, ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_data, r_id, r_resp, r_last
  );
  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, w_valid, w_data, w_strb, w_last,
           b_ready, ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_data, r_id, r_resp, r_last
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: single-outstanding AXI4 slave memory over a synchronous RAM
// ports: clock, reset_n (async assert, sync release), bus (axi4_mem_if.slave: AW/W/B/AR/R)
module axi4_mem_responder #(
  parameter int ID_W = 6,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int IDX_W = 14
) (
  input logic clock,
  input logic reset_n,
  axi4_mem_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREQ, RDATA} state_t;
  state_t state, state_n;
  logic [1:0] rst_sync;
  logic rst_n_i;
  logic [ADDR_W-1:0] addr, step;
  logic [ID_W-1:0] id;
  logic [7:0] len, beat;
  logic [2:0] size;
  logic [1:0] burst;
  logic ovf, err, last_wr;
  logic aw_hs, ar_hs, w_hs, b_hs, r_hs, last_beat, excess, short_last, we;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] mem [2**IDX_W];
  logic [DATA_W-1:0] rdata;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n_i = rst_sync[1];
  assign idx = addr[IDX_W+2:3];
  assign step = burst == 2'b00 ? '0 : ADDR_W'(1) << size;
  assign aw_hs = bus.aw_valid && bus.aw_ready;
  assign ar_hs = bus.ar_valid && bus.ar_ready;
  assign w_hs = state == WDATA && bus.w_valid;
  assign b_hs = state == WRESP && bus.b_ready;
  assign r_hs = state == RDATA && bus.r_ready;
  assign last_beat = beat == len;
  assign excess = ovf || beat > len;
  assign short_last = bus.w_last && !last_beat;
  // the beat carrying an early or late w_last is dropped; earlier beats are already committed
  assign we = w_hs && !err && !excess && !short_last;
  always_comb begin
    state_n = state;
    bus.aw_ready = 1'b0;
    bus.ar_ready = 1'b0;
    bus.w_ready = 1'b0;
    bus.b_valid = 1'b0;
    bus.b_id = '0;
    bus.b_resp = 2'b00;
    bus.r_valid = 1'b0;
    bus.r_data = '0;
    bus.r_id = '0;
    bus.r_resp = 2'b00;
    bus.r_last = 1'b0;
    case (state)
      IDLE: begin
        bus.aw_ready = rst_n_i && bus.aw_valid && (!bus.ar_valid || !last_wr);
        bus.ar_ready = rst_n_i && bus.ar_valid && (!bus.aw_valid || last_wr);
        state_n = bus.aw_ready ? WDATA : bus.ar_ready ? RREQ : IDLE;
      end
      WDATA: begin
        bus.w_ready = 1'b1;
        state_n = bus.w_valid && bus.w_last ? WRESP : WDATA;
      end
      WRESP: begin
        bus.b_valid = 1'b1;
        bus.b_id = id;
        bus.b_resp = {err, 1'b0};
        state_n = bus.b_ready ? IDLE : WRESP;
      end
      RREQ: state_n = RDATA;
      RDATA: begin
        bus.r_valid = 1'b1;
        bus.r_data = err ? '0 : rdata;
        bus.r_id = id;
        bus.r_resp = {err, 1'b0};
        bus.r_last = last_beat;
        state_n = !bus.r_ready ? RDATA : last_beat ? IDLE : RREQ;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= IDLE;
      last_wr <= 1'b0;
      addr <= '0;
      id <= '0;
      len <= '0;
      size <= '0;
      burst <= '0;
      beat <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (aw_hs || ar_hs) begin
        addr <= aw_hs ? bus.aw_addr : bus.ar_addr;
        id <= aw_hs ? bus.aw_id : bus.ar_id;
        len <= aw_hs ? bus.aw_len : bus.ar_len;
        size <= aw_hs ? bus.aw_size : bus.ar_size;
        burst <= aw_hs ? bus.aw_burst : bus.ar_burst;
        err <= aw_hs ? (&bus.aw_burst || bus.aw_size > 3'd3) : (&bus.ar_burst || bus.ar_size > 3'd3);
        beat <= '0;
        ovf <= 1'b0;
      end
      if (w_hs) begin
        beat <= beat + 8'd1;
        ovf <= ovf | (&beat);
        addr <= addr + step;
        err <= err | excess | short_last;
      end
      if (b_hs) last_wr <= 1'b1;
      if (r_hs && last_beat) last_wr <= 1'b0;
      if (r_hs && !last_beat) begin
        addr <= addr + step;
        beat <= beat + 8'd1;
      end
    end
  always_ff @(posedge clock) begin
    for (int i = 0; i < DATA_W/8; i++)
      if (we && bus.w_strb[i]) mem[idx][8*i +: 8] <= bus.w_data[8*i +: 8];
    if (state == RREQ) rdata <= mem[idx];
  end
endmodule
